usr_reg_led_seq: RTL and testbench

Command-driven LED blink sequencer in the `clk25` domain. The MCU writes 16-bit command words onto `usr_reg`; this block decodes them, holds the blink configuration, and generates the blink pattern itself. It drives the fabric LED and returns an acknowledge toggle and an error flag for MCU readback. It replaces the free-running counter bit as the `hw_led` source.

---
 rtl/led_seq_pkg.sv | 33 +++
 rtl/led_tick_gen.sv | 30 +++
 rtl/usr_reg_led_seq.sv | 179 +++++++++++++++++
 tb/tb_usr_reg_led_seq.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED blink sequencer: command layout, opcodes,
// FSM states and configuration reset defaults.
`timescale 1ns/1ps
package led_seq_pkg;

   typedef enum logic [2:0] {
      OP_NOP        = 3'b000,
      OP_SET_PERIOD = 3'b001,
      OP_SET_DUTY   = 3'b010,
      OP_START      = 3'b011,
      OP_STOP       = 3'b100,
      OP_FORCE      = 3'b101,
      OP_RSVD6      = 3'b110,
      OP_RSVD7      = 3'b111
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } state_e;

   // Command word as written by the MCU: toggle, opcode, argument.
   typedef struct packed {
      logic       tgl;
      opcode_e    op;
      logic [11:0] arg;
   } cmd_t;

   localparam logic [11:0] DEF_PERIOD = 12'd1000;
   localparam logic [11:0] DEF_DUTY   = 12'd500;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler producing a one-cycle tick every PRESCALE cycles while run is high;
// the count is held at zero whenever run is low so each run starts a fresh period.
`timescale 1ns/1ps
module led_tick_gen #(
   parameter int PRESCALE = 25000,
   parameter int PRE_W    = 15
) (
   input  logic clk25,
   input  logic fpga_rst,
   input  logic run,
   output logic tick
);

   localparam logic [PRE_W-1:0] LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] cnt;

   assign tick = run && (cnt == LAST);

   always_ff @(posedge clk25) begin
      if (fpga_rst || !run) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/usr_reg_led_seq.sv
// Command-driven LED blink sequencer: decodes toggle-handshaked MCU command words,
// holds the blink configuration and runs the ON/OFF pattern on hw_led.
`timescale 1ns/1ps
module usr_reg_led_seq
   import led_seq_pkg::*;
#(
   parameter int PRESCALE = 25000,
   parameter int PRE_W    = 15
) (
   input  logic        clk25,
   input  logic        fpga_rst,
   input  logic [15:0] usr_reg,
   output logic        led_out,
   output logic        busy,
   output logic        ack_tgl,
   output logic        err
);

   cmd_t        cmd_q;
   logic        last_tgl;
   logic [11:0] period_r;
   logic [11:0] duty_r;
   logic [11:0] count_r;
   logic        force_r;
   logic [11:0] phase_cnt;
   state_e      state;

   state_e      state_n;
   logic [11:0] period_n;
   logic [11:0] duty_n;
   logic [11:0] count_n;
   logic        force_n;
   logic [11:0] phase_n;
   logic        err_n;
   logic        last_n;
   logic        ack_n;
   logic        led_n;
   logic        busy_n;
   logic        cmd_hit;
   logic        is_busy;
   logic        run;
   logic        tick;

   assign run = (state != ST_IDLE);

   led_tick_gen #(
      .PRESCALE (PRESCALE),
      .PRE_W    (PRE_W)
   ) u_tick (
      .clk25    (clk25),
      .fpga_rst (fpga_rst),
      .run      (run),
      .tick     (tick)
   );

   always_ff @(posedge clk25) begin
      if (fpga_rst) begin
         cmd_q     <= '0;
         last_tgl  <= 1'b0;
         ack_tgl   <= 1'b0;
         err       <= 1'b0;
         period_r  <= DEF_PERIOD;
         duty_r    <= DEF_DUTY;
         count_r   <= 12'd0;
         force_r   <= 1'b0;
         phase_cnt <= 12'd0;
         state     <= ST_IDLE;
         led_out   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         cmd_q     <= cmd_t'(usr_reg);
         last_tgl  <= last_n;
         ack_tgl   <= ack_n;
         err       <= err_n;
         period_r  <= period_n;
         duty_r    <= duty_n;
         count_r   <= count_n;
         force_r   <= force_n;
         phase_cnt <= phase_n;
         state     <= state_n;
         led_out   <= led_n;
         busy      <= busy_n;
      end
   end

   // Phase sequencing is evaluated first so that a command in the same cycle,
   // notably STOP, overrides a phase-ending tick.
   always_comb begin
      state_n  = state;
      period_n = period_r;
      duty_n   = duty_r;
      count_n  = count_r;
      force_n  = force_r;
      phase_n  = phase_cnt;
      err_n    = err;
      last_n   = last_tgl;
      ack_n    = ack_tgl;
      led_n    = 1'b0;
      busy_n   = 1'b0;
      is_busy  = (state != ST_IDLE);
      cmd_hit  = (cmd_q.tgl != last_tgl);

      if (tick) begin
         case (state)
            ST_ON: begin
               if (phase_cnt == 12'd1) begin
                  state_n = ST_OFF;
                  phase_n = period_r - duty_r;
               end else begin
                  phase_n = phase_cnt - 12'd1;
               end
            end
            ST_OFF: begin
               if (phase_cnt == 12'd1) begin
                  if (count_r == 12'd1) begin
                     state_n = ST_IDLE;
                  end else begin
                     state_n = ST_ON;
                     phase_n = duty_r;
                     if (count_r != 12'd0) begin
                        count_n = count_r - 12'd1;
                     end
                  end
               end else begin
                  phase_n = phase_cnt - 12'd1;
               end
            end
            default: begin
            end
         endcase
      end

      if (cmd_hit) begin
         last_n = cmd_q.tgl;
         ack_n  = cmd_q.tgl;
         case (cmd_q.op)
            OP_NOP: begin
               err_n = 1'b0;
            end
            OP_SET_PERIOD: begin
               if (cmd_q.arg == 12'd0 || is_busy) err_n = 1'b1;
               else                              period_n = cmd_q.arg;
            end
            OP_SET_DUTY: begin
               if (cmd_q.arg == 12'd0 || is_busy) err_n = 1'b1;
               else                              duty_n = cmd_q.arg;
            end
            OP_START: begin
               // duty < period keeps the OFF reload (period - duty) nonzero.
               if (is_busy || duty_r >= period_r) begin
                  err_n = 1'b1;
               end else begin
                  state_n = ST_ON;
                  phase_n = duty_r;
                  count_n = cmd_q.arg;
               end
            end
            OP_STOP: begin
               state_n = ST_IDLE;
            end
            OP_FORCE: begin
               if (is_busy) err_n = 1'b1;
               else         force_n = cmd_q.arg[0];
            end
            default: begin
               err_n = 1'b1;
            end
         endcase
      end

      case (state_n)
         ST_ON:   led_n = 1'b1;
         ST_OFF:  led_n = 1'b0;
         default: led_n = force_n;
      endcase
      busy_n = (state_n != ST_IDLE);
   end

endmodule

// File: tb/tb_usr_reg_led_seq.sv
// Scenario bench for usr_reg_led_seq with a short prescaler; expected LED/busy
// waveforms are queued when a blink is launched and popped cycle by cycle.
`timescale 1ns/1ps
module tb_usr_reg_led_seq;
   import led_seq_pkg::*;

   logic        clk25 = 1'b0;
   logic        fpga_rst;
   logic [15:0] usr_reg;
   logic        led_out;
   logic        busy;
   logic        ack_tgl;
   logic        err;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic my_tgl   = 1'b0;
   logic exp_led[$];
   logic exp_busy[$];

   usr_reg_led_seq #(
      .PRESCALE (4),
      .PRE_W    (3)
   ) dut (
      .clk25    (clk25),
      .fpga_rst (fpga_rst),
      .usr_reg  (usr_reg),
      .led_out  (led_out),
      .busy     (busy),
      .ack_tgl  (ack_tgl),
      .err      (err)
   );

   always #5 clk25 = ~clk25;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk25);
      #1;
   endtask

   task automatic drive_cmd(input logic [2:0] op, input logic [11:0] arg);
      my_tgl  = ~my_tgl;
      usr_reg = {my_tgl, op, arg};
   endtask

   task automatic send_cmd(input logic [2:0] op, input logic [11:0] arg);
      drive_cmd(op, arg);
      step();
      step();
   endtask

   // Expected waveform from phase lengths: sample s is the s-th edge after the
   // launching command took effect (s = 1 is the first ON cycle).
   task automatic push_pattern(input int on_len, input int off_len, input int blinks,
                               input int total, input int stop_at, input logic idle_led);
      int per_len;
      int pos;
      int idx;
      per_len = on_len + off_len;
      for (int s = 1; s <= total; s++) begin
         pos = (s - 1) % per_len;
         idx = (s - 1) / per_len;
         if ((stop_at != 0 && s >= stop_at) || (blinks != 0 && idx >= blinks)) begin
            exp_led.push_back(idle_led);
            exp_busy.push_back(1'b0);
         end else begin
            exp_led.push_back(pos < on_len);
            exp_busy.push_back(1'b1);
         end
      end
   endtask

   task automatic test_reset();
      fpga_rst = 1'b1;
      usr_reg  = 16'h0000;
      my_tgl   = 1'b0;
      repeat (3) step();
      n_checks++;
      if ({led_out, busy, ack_tgl, err} !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL reset_values: got %b expected 0000", {led_out, busy, ack_tgl, err});
      end
      fpga_rst = 1'b0;
      for (int c = 0; c < 100; c++) begin
         step();
         n_checks++;
         if ({led_out, busy, ack_tgl, err} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL idle_hold c=%0d: got %b expected 0000", c, {led_out, busy, ack_tgl, err});
         end
      end
   endtask

   task automatic test_blink();
      logic [2:0]  cfg_op [2];
      logic [11:0] cfg_arg [2];
      logic        el;
      logic        eb;
      cfg_op[0] = OP_SET_PERIOD; cfg_arg[0] = 12'd4;
      cfg_op[1] = OP_SET_DUTY;   cfg_arg[1] = 12'd1;
      for (int i = 0; i < 2; i++) begin
         drive_cmd(cfg_op[i], cfg_arg[i]);
         step();
         n_checks++;
         if (ack_tgl !== ~my_tgl) begin
            n_fail++;
            $display("[TB] FAIL ack_early cfg%0d: got %b expected %b", i, ack_tgl, ~my_tgl);
         end
         step();
         n_checks++;
         if (ack_tgl !== my_tgl || err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ack_cfg%0d: ack=%b err=%b, expected ack=%b err=0", i, ack_tgl, err, my_tgl);
         end
      end
      drive_cmd(OP_START, 12'd2);
      push_pattern(4, 12, 2, 36, 0, 1'b0);
      step();
      n_checks++;
      if (ack_tgl !== ~my_tgl || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL start_early: ack=%b busy=%b, expected ack=%b busy=0", ack_tgl, busy, ~my_tgl);
      end
      for (int s = 1; s <= 36; s++) begin
         step();
         el = exp_led.pop_front();
         eb = exp_busy.pop_front();
         n_checks++;
         if (led_out !== el || busy !== eb) begin
            n_fail++;
            $display("[TB] FAIL blink2 s=%0d: led=%b busy=%b, expected led=%b busy=%b", s, led_out, busy, el, eb);
         end
         if (s == 1) begin
            n_checks++;
            if (ack_tgl !== my_tgl) begin
               n_fail++;
               $display("[TB] FAIL ack_start: got %b expected %b", ack_tgl, my_tgl);
            end
         end
      end
   endtask

   task automatic test_stop();
      logic el;
      logic eb;
      drive_cmd(OP_START, 12'd0);
      push_pattern(4, 12, 0, 40, 36, 1'b0);
      step();
      for (int s = 1; s <= 40; s++) begin
         step();
         el = exp_led.pop_front();
         eb = exp_busy.pop_front();
         n_checks++;
         if (led_out !== el || busy !== eb) begin
            n_fail++;
            $display("[TB] FAIL blink_inf s=%0d: led=%b busy=%b, expected led=%b busy=%b", s, led_out, busy, el, eb);
         end
         if (s == 34) drive_cmd(OP_STOP, 12'd0);
      end
   endtask

   task automatic test_reject();
      send_cmd(OP_SET_PERIOD, 12'd8);
      send_cmd(OP_SET_DUTY, 12'd8);
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL cfg8_err: got %b expected 0", err);
      end
      send_cmd(OP_START, 12'd0);
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0 || ack_tgl !== my_tgl || led_out !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL start_dutyeq: err=%b busy=%b ack=%b led=%b, expected 1 0 %b 0", err, busy, ack_tgl, led_out, my_tgl);
      end
      send_cmd(OP_NOP, 12'd0);
      n_checks++;
      if (err !== 1'b0 || ack_tgl !== my_tgl) begin
         n_fail++;
         $display("[TB] FAIL nop_clear: err=%b ack=%b, expected 0 %b", err, ack_tgl, my_tgl);
      end
      send_cmd(OP_SET_PERIOD, 12'd0);
      n_checks++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL period_zero: got %b expected 1", err);
      end
      send_cmd(OP_NOP, 12'd0);
      send_cmd(OP_SET_DUTY, 12'd0);
      n_checks++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL duty_zero: got %b expected 1", err);
      end
      send_cmd(OP_NOP, 12'd0);
      send_cmd(OP_SET_DUTY, 12'd2);
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL duty2_err: got %b expected 0", err);
      end
   endtask

   task automatic test_busy_reject();
      logic el;
      logic eb;
      drive_cmd(OP_START, 12'd0);
      push_pattern(8, 24, 0, 44, 42, 1'b0);
      step();
      for (int s = 1; s <= 44; s++) begin
         step();
         el = exp_led.pop_front();
         eb = exp_busy.pop_front();
         n_checks++;
         if (led_out !== el || busy !== eb) begin
            n_fail++;
            $display("[TB] FAIL busy_blink s=%0d: led=%b busy=%b, expected led=%b busy=%b", s, led_out, busy, el, eb);
         end
         if (s == 5 || s == 9 || s == 13) begin
            n_checks++;
            if (err !== 1'b1 || ack_tgl !== my_tgl) begin
               n_fail++;
               $display("[TB] FAIL busy_rej s=%0d: err=%b ack=%b, expected 1 %b", s, err, ack_tgl, my_tgl);
            end
         end
         if (s == 7 || s == 11) begin
            n_checks++;
            if (err !== 1'b0) begin
               n_fail++;
               $display("[TB] FAIL busy_nop s=%0d: got %b expected 0", s, err);
            end
         end
         case (s)
            3:  drive_cmd(OP_SET_PERIOD, 12'd3);
            5:  drive_cmd(OP_NOP, 12'd0);
            7:  drive_cmd(OP_FORCE, 12'd1);
            9:  drive_cmd(OP_NOP, 12'd0);
            11: drive_cmd(3'b111, 12'd0);
            40: drive_cmd(OP_STOP, 12'd0);
            default: begin
            end
         endcase
      end
      send_cmd(OP_FORCE, 12'd1);
      n_checks++;
      if (led_out !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL force_on: led=%b busy=%b, expected 1 0", led_out, busy);
      end
   endtask

   task automatic test_reset_mid_off();
      logic el;
      logic eb;
      drive_cmd(OP_START, 12'd0);
      push_pattern(8, 24, 0, 12, 0, 1'b1);
      step();
      for (int s = 1; s <= 12; s++) begin
         step();
         el = exp_led.pop_front();
         eb = exp_busy.pop_front();
         n_checks++;
         if (led_out !== el || busy !== eb) begin
            n_fail++;
            $display("[TB] FAIL pre_rst s=%0d: led=%b busy=%b, expected led=%b busy=%b", s, led_out, busy, el, eb);
         end
      end
      fpga_rst = 1'b1;
      usr_reg  = 16'h0000;
      my_tgl   = 1'b0;
      step();
      n_checks++;
      if ({led_out, busy, ack_tgl, err} !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL mid_rst: got %b expected 0000", {led_out, busy, ack_tgl, err});
      end
      fpga_rst = 1'b0;
      step();
      step();
      n_checks++;
      if ({led_out, busy, ack_tgl, err} !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL post_rst: got %b expected 0000", {led_out, busy, ack_tgl, err});
      end
      drive_cmd(OP_START, 12'd1);
      push_pattern(2000, 2000, 1, 4002, 0, 1'b0);
      step();
      for (int s = 1; s <= 4002; s++) begin
         step();
         el = exp_led.pop_front();
         eb = exp_busy.pop_front();
         n_checks++;
         if (led_out !== el || busy !== eb) begin
            n_fail++;
            $display("[TB] FAIL default_blink s=%0d: led=%b busy=%b, expected led=%b busy=%b", s, led_out, busy, el, eb);
         end
      end
   endtask

   initial begin
      fpga_rst = 1'b1;
      usr_reg  = 16'h0000;
      test_reset();
      test_blink();
      test_stop();
      test_reject();
      test_busy_reject();
      test_reset_mid_off();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
